// File: rtl/tick_monitor_if.sv
// Signal bundle between a slow timing source and tick_monitor.
// The master modport drives sig_in. The slave modport (the monitor) drives the measurement outputs.
interface tick_monitor_if;
    logic        sig_in;
    logic        tick;
    logic        meas_valid;
    logic [27:0] period;
    logic [27:0] high_time;
    logic        period_err;
    logic        lost;
    logic [5:0]  sec;
    logic [5:0]  min;

    modport master (
        output sig_in,
        input  tick, meas_valid, period, high_time, period_err, lost, sec, min
    );

    modport slave (
        input  sig_in,
        output tick, meas_valid, period, high_time, period_err, lost, sec, min
    );
endinterface

// File: rtl/tick_monitor.sv
// Measures the period and high time of a slow asynchronous square wave and flags loss of signal.
// Define TICK_MONITOR_CLOCK_EN to add a seconds/minutes counter that advances on each tick.
module tick_monitor #(
    parameter int NOMINAL_PERIOD = 100000001,
    parameter int TOLERANCE      = 1000,
    parameter int TIMEOUT        = 200000002
) (
    input  logic           clk,
    input  logic           rst,
    tick_monitor_if.slave  bus
);
    localparam int          W    = 28;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] NOM  = W'(NOMINAL_PERIOD);
    localparam logic [W-1:0] TOL  = W'(TOLERANCE);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t         state, state_nxt;
    logic           sync_p0, sync_p1, hist_p2;
    logic           rise, fall, timeout;
    logic           publish, missed, latch_cand, set_lost, run_cnt;
    logic [W-1:0]   cnt, cand, cnt_inc;
    logic           tick_r, mv_r, perr_r, lost_r;
    logic [W-1:0]   period_r, high_r;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v >= LAST) ? LAST : v + W'(1);
    endfunction

    function automatic logic out_of_tol(input logic [W-1:0] p);
        logic [W-1:0] d;
        d = (p >= NOM) ? p - NOM : NOM - p;
        return d > TOL;
    endfunction

    // Stage boundary: two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            sync_p0 <= bus.sig_in;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign rise    = sync_p1 & ~hist_p2;
    assign fall    = ~sync_p1 & hist_p2;
    assign timeout = (cnt == LAST);
    // cnt never exceeds TIMEOUT-1, so cnt+1 fits in W bits.
    assign cnt_inc = cnt + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = HIGH;
            HIGH: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = IDLE;
                else if (fall)    state_nxt = LOW;
            end
            LOW: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        publish    = (state != IDLE) && rise;
        missed     = (state == HIGH) && rise;
        latch_cand = (state == HIGH) && fall && !rise;
        set_lost   = (state != IDLE) && timeout && !rise;
        run_cnt    = (state != IDLE);
    end

    // Stage boundary: registered measurement outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cand     <= '0;
            tick_r   <= 1'b0;
            mv_r     <= 1'b0;
            period_r <= '0;
            high_r   <= '0;
            perr_r   <= 1'b0;
            lost_r   <= 1'b0;
        end else begin
            tick_r <= rise;
            mv_r   <= publish;
            if (rise)                     cnt <= '0;
            else if (run_cnt && !set_lost) cnt <= sat_inc(cnt);
            if (latch_cand) cand <= cnt_inc;
            if (publish) begin
                period_r <= cnt_inc;
                high_r   <= missed ? cnt_inc : cand;
                perr_r   <= out_of_tol(cnt_inc);
            end
            if (rise)          lost_r <= 1'b0;
            else if (set_lost) lost_r <= 1'b1;
        end
    end

`ifdef TICK_MONITOR_CLOCK_EN
    logic [5:0] sec_r, min_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_r <= '0;
            min_r <= '0;
        end else if (rise && !lost_r) begin
            if (sec_r == 6'd59) begin
                sec_r <= '0;
                min_r <= (min_r == 6'd59) ? 6'd0 : min_r + 6'd1;
            end else begin
                sec_r <= sec_r + 6'd1;
            end
        end
    end

    assign bus.sec = sec_r;
    assign bus.min = min_r;
`else
    assign bus.sec = '0;
    assign bus.min = '0;
`endif

    assign bus.tick       = tick_r;
    assign bus.meas_valid = mv_r;
    assign bus.period     = period_r;
    assign bus.high_time  = high_r;
    assign bus.period_err = perr_r;
    assign bus.lost       = lost_r;
endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter NOMINAL_PERIOD, default 100000001, expected sig_in period in clk cycles.
REQ-002 Parameter TOLERANCE, default 1000, allowed absolute period deviation in cycles.
REQ-003 Parameter TIMEOUT, default 200000002, cycles without a rising edge before loss is declared; SHALL be < 2^28.
REQ-004 clk  input  1  system clock; all state on posedge clk.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 sig_in  input  1  slow square-wave timing input, asynchronous to clk.
REQ-007 tick  output  1  one-cycle pulse per detected rising edge of sig_in.
REQ-008 meas_valid  output  1  one-cycle pulse when period/high_time are updated.
REQ-009 period  output  28  last measured rise-to-rise interval, clk cycles.
REQ-010 high_time  output  28  last measured rise-to-fall interval, clk cycles.
REQ-011 period_err  output  1  last published period outside NOMINAL_PERIOD +/- TOLERANCE.
REQ-012 lost  output  1  sticky: no rising edge within TIMEOUT cycles.
REQ-013 sec  output  6  seconds count 0-59 (see Configuration).
REQ-014 min  output  6  minutes count 0-59 (see Configuration).

Function
REQ-015 sig_in SHALL pass a 2-flop synchronizer plus a history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-016 tick SHALL be registered, asserting exactly 3 clk edges after the first edge sampling sig_in high.
REQ-017 FSM states IDLE, HIGH, LOW; reset -> IDLE.
REQ-018 IDLE: on rise -> HIGH, clear cnt to 0, no meas_valid.
REQ-019 HIGH: cnt increments each cycle; on fall latch high_time candidate = cnt+1, -> LOW.
REQ-020 LOW: cnt increments; on rise publish period = cnt+1, high_time = candidate, pulse meas_valid, clear cnt, -> HIGH.
REQ-021 Rise while in HIGH (missed fall) SHALL publish period = cnt+1 and high_time = cnt+1, pulse meas_valid, stay HIGH.
REQ-022 period_err SHALL update in the same cycle as meas_valid: 1 iff |period - NOMINAL_PERIOD| > TOLERANCE; hold otherwise.
REQ-023 In HIGH or LOW, when cnt reaches TIMEOUT-1 without rise: lost <= 1, state -> IDLE, cnt held; no meas_valid.
REQ-024 lost SHALL clear on the next tick; rise and timeout in the same cycle: rise wins, lost unchanged (stays 0).
REQ-025 cnt SHALL never wrap: saturates at TIMEOUT-1.
REQ-026 tick SHALL pulse on every rise including from IDLE; meas_valid never pulses on the first rise after reset or loss.

Reset
REQ-027 rst asserted SHALL immediately force: state IDLE, cnt 0, synchronizer/history 0, tick 0, meas_valid 0, period 0, high_time 0, period_err 0, lost 0, sec 0, min 0.
REQ-028 rst mid-measurement SHALL discard the partial measurement; first rise after release is treated as from IDLE.

Configuration
REQ-029 Macro TICK_MONITOR_CLOCK_EN defined: sec increments on each tick while lost=0, wraps 59->0 incrementing min; min wraps 59->0.
REQ-030 Macro undefined: sec and min SHALL be constant 0, no counter logic instantiated; all other behaviour identical.

Verification (NOMINAL_PERIOD=11, TOLERANCE=1, TIMEOUT=30)
REQ-031 sig_in 5 cycles high / 6 low, repeated 4 periods -> tick every 11 cycles, meas_valid x3, period=11, high_time=5, period_err=0.
REQ-032 Period changed to 14 cycles (7/7) -> next meas_valid with period=14, high_time=7, period_err=1.
REQ-033 sig_in held low 40 cycles after a rise -> lost=1 exactly 30 cycles after that rise's cnt clear, state IDLE; next rise -> tick, lost=0, no meas_valid; following rise -> meas_valid.
REQ-034 rst pulse of 2 cycles mid-HIGH -> all outputs 0 asynchronously; first subsequent rise produces tick but no meas_valid.
REQ-035 With TICK_MONITOR_CLOCK_EN, 61 ticks -> sec=1, min=1; without macro sec=min=0 throughout.
REQ-036 sig_in 1-cycle low glitch inside HIGH -> fall then rise detected, period=observed rise spacing, period_err=1.
